// File: rtl/pepper_window_corrector.sv
// Serial 3x3 pepper-noise corrector: accumulates non-pepper neighbours of a raster-order
// window and replaces a pepper centre with their truncated mean from a restoring divider.
module pepper_window_corrector #(
  parameter int unsigned DIV_BITS = 11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] pix_in,
  input  logic       pix_valid,
  output logic       pix_ready,
  output logic [7:0] out_pix,
  output logic       out_corrected,
  output logic       out_valid,
  input  logic       out_ready
);

  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_DIV  = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;

  localparam logic [3:0] IDX_CENTRE = 4'd4;
  localparam logic [3:0] IDX_LAST   = 4'd8;
  localparam logic [3:0] STEP_LAST  = 4'(DIV_BITS - 1);

  logic [1:0]          state_q, state_d;
  logic [3:0]          idx_q, idx_d;
  logic [DIV_BITS-1:0] sum_q, sum_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [7:0]          ctr_q, ctr_d;
  logic                ctr_pep_q, ctr_pep_d;
  logic [DIV_BITS-1:0] quo_q, quo_d;
  logic [2:0]          rem_q, rem_d;
  logic [3:0]          step_q, step_d;
  logic [7:0]          out_pix_q, out_pix_d;
  logic                out_corr_q, out_corr_d;

  logic                pix_pep;
  logic [3:0]          rem_shift;
  logic                rem_ge;

  assign pix_pep = (pix_in == 8'h00);

  // Divisor never exceeds 8, so the partial remainder stays below 8 and the
  // shifted remainder fits in 4 bits.
  assign rem_shift = {rem_q, quo_q[DIV_BITS-1]};
  assign rem_ge    = (rem_shift >= cnt_q);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    sum_d      = sum_q;
    cnt_d      = cnt_q;
    ctr_d      = ctr_q;
    ctr_pep_d  = ctr_pep_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    step_d     = step_q;
    out_pix_d  = out_pix_q;
    out_corr_d = out_corr_q;

    case (state_q)
      ST_LOAD: begin
        if (pix_valid) begin
          if (idx_q == IDX_CENTRE) begin
            ctr_d     = pix_in;
            ctr_pep_d = pix_pep;
          end else if (!pix_pep) begin
            sum_d = sum_q + DIV_BITS'(pix_in);
            cnt_d = cnt_q + 4'd1;
          end

          if (idx_q == IDX_LAST) begin
            idx_d = '0;
            // Decision uses the totals including pixel 8, hence the _d values.
            if (ctr_pep_q && (cnt_d != 4'd0)) begin
              state_d = ST_DIV;
              quo_d   = sum_d;
              rem_d   = '0;
              step_d  = '0;
            end else begin
              state_d    = ST_OUT;
              out_pix_d  = ctr_pep_q ? 8'h00 : ctr_q;
              out_corr_d = 1'b0;
            end
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end

      ST_DIV: begin
        rem_d  = 3'(rem_ge ? (rem_shift - cnt_q) : rem_shift);
        quo_d  = {quo_q[DIV_BITS-2:0], rem_ge};
        step_d = step_q + 4'd1;
        if (step_q == STEP_LAST) begin
          state_d    = ST_OUT;
          out_pix_d  = quo_d[7:0];
          out_corr_d = 1'b1;
        end
      end

      ST_OUT: begin
        if (out_ready) begin
          state_d = ST_LOAD;
          sum_d   = '0;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end

      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_LOAD;
      idx_q      <= '0;
      sum_q      <= '0;
      cnt_q      <= '0;
      ctr_q      <= '0;
      ctr_pep_q  <= 1'b0;
      quo_q      <= '0;
      rem_q      <= '0;
      step_q     <= '0;
      out_pix_q  <= '0;
      out_corr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      sum_q      <= sum_d;
      cnt_q      <= cnt_d;
      ctr_q      <= ctr_d;
      ctr_pep_q  <= ctr_pep_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      step_q     <= step_d;
      out_pix_q  <= out_pix_d;
      out_corr_q <= out_corr_d;
    end
  end

  assign pix_ready     = (state_q == ST_LOAD);
  assign out_valid     = (state_q == ST_OUT);
  assign out_pix       = out_pix_q;
  assign out_corrected = out_corr_q;

endmodule

// File: tb/tb_pepper_window_corrector.sv
// Directed bench for pepper_window_corrector: hand-computed windows, latency,
// reset recovery and output back-pressure.
module tb_pepper_window_corrector;

  logic       clk;
  logic       rst;
  logic [7:0] pix_in;
  logic       pix_valid;
  logic       pix_ready;
  logic [7:0] out_pix;
  logic       out_corrected;
  logic       out_valid;
  logic       out_ready;

  int n_cmp;
  int n_bad;
  logic [7:0] win [9];

  pepper_window_corrector #(.DIV_BITS(11)) dut (
    .clk(clk),
    .rst(rst),
    .pix_in(pix_in),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .out_pix(out_pix),
    .out_corrected(out_corrected),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Offer one pixel after 'gap' idle cycles; returns after the accepting edge.
  task automatic send_pix(input logic [7:0] p, input int gap);
    int guard;
    guard = 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    while (!pix_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) chk("pix_ready_timeout", 32'(guard), 32'd0);
    pix_in    = p;
    pix_valid = 1'b1;
    @(posedge clk);
    #1 pix_valid = 1'b0;
  endtask

  // Loads win[], measures latency to out_valid and checks the result; leaves
  // the bench at the negedge where out_valid was first seen.
  task automatic run_window(input string tag, input logic [7:0] exp_pix,
                            input logic exp_corr, input int exp_lat, input int gap);
    int lat;
    for (int i = 0; i < 9; i++) send_pix(win[i], gap);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 200);
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_out_pix"}, 32'(out_pix), 32'(exp_pix));
    chk({tag, "_out_corrected"}, 32'(out_corrected), 32'(exp_corr));
    chk({tag, "_no_ready_in_out"}, 32'(pix_ready), 32'd0);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    pix_valid = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    chk({tag, "_ready_back"}, 32'(pix_ready), 32'd1);
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    rst       = 1'b1;
    pix_in    = 8'h00;
    pix_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_pix", 32'(out_pix), 32'd0);
    chk("reset_out_corrected", 32'(out_corrected), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_pix_ready", 32'(pix_ready), 32'd1);

    // 360/8 = 45
    win = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd0, 8'd50, 8'd60, 8'd70, 8'd80};
    run_window("w_mean45", 8'd45, 1'b1, 12, 0);
    handshake("w_mean45");

    // 13/2 = 6 (truncated)
    win = '{8'd0, 8'd0, 8'd9, 8'd0, 8'd0, 8'd0, 8'd4, 8'd0, 8'd0};
    run_window("w_trunc6", 8'd6, 1'b1, 12, 0);
    handshake("w_trunc6");

    // No usable neighbours: fallback, no divide
    win = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    run_window("w_allzero", 8'd0, 1'b0, 1, 0);
    handshake("w_allzero");

    win = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd128, 8'd255, 8'd255, 8'd255, 8'd255};
    run_window("w_pass128", 8'd128, 1'b0, 1, 0);
    handshake("w_pass128");

    // 2040/8 = 255, widest dividend
    win = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd0, 8'd255, 8'd255, 8'd255, 8'd255};
    run_window("w_max255", 8'd255, 1'b1, 12, 0);
    handshake("w_max255");

    // Reset during the fifth divide cycle
    win = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd0, 8'd50, 8'd60, 8'd70, 8'd80};
    for (int i = 0; i < 9; i++) send_pix(win[i], 0);
    repeat (5) @(negedge clk);
    chk("mid_div_busy", 32'(pix_ready), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_out_valid", 32'(out_valid), 32'd0);
    chk("rst_async_out_pix", 32'(out_pix), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_recover_ready", 32'(pix_ready), 32'd1);
    chk("rst_recover_valid", 32'(out_valid), 32'd0);

    // 8/8 = 1, fed with idle gaps; a stale sum/idx would change the result
    win = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd0, 8'd1, 8'd1, 8'd1, 8'd1};
    run_window("w_after_rst", 8'd1, 1'b1, 12, 2);
    handshake("w_after_rst");

    // Back-pressure: hold out_ready low with a pixel offered
    win = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd0, 8'd50, 8'd60, 8'd70, 8'd80};
    run_window("w_hold", 8'd45, 1'b1, 12, 0);
    pix_in    = 8'd77;
    pix_valid = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      chk("hold_out_pix", 32'(out_pix), 32'd45);
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_pix_ready", 32'(pix_ready), 32'd0);
    end
    handshake("w_hold");

    // 10/2 = 5; any swallowed 77 would shift the window
    win = '{8'd3, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd7};
    run_window("w_post_hold", 8'd5, 1'b1, 12, 0);
    handshake("w_post_hold");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
